// File: rtl/axi_burst_pkg.sv
// Shared response codes, FSM state encodings and address-range helper
// for the burst responder.
package axi_burst_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
        return int'({24'd0, addr}) < depth;
    endfunction

endpackage

// File: rtl/axi_burst_ram.sv
// Byte storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module axi_burst_ram
    import axi_burst_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_responder.sv
// Memory-backed responder for read and write bursts; the two paths run
// independently and share one byte array.
//
// state  | meaning
// R_IDLE | waiting for AR, ARREADY high
// R_DATA | streaming read beats on R
// W_IDLE | waiting for AW, AWREADY high
// W_DATA | absorbing AWLEN+1 write beats
// W_RESP | holding write response until BREADY
module axi_burst_responder
    import axi_burst_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ARVALID,
    input  logic [7:0] ARADDR,
    input  logic [3:0] ARLEN,
    input  logic [3:0] ARID,
    output logic       ARREADY,
    output logic       RVALID,
    input  logic       RREADY,
    output logic [7:0] RDATA,
    output logic [1:0] RRESP,
    output logic [3:0] RID,
    output logic       RLAST,
    input  logic       AWVALID,
    input  logic [7:0] AWADDR,
    input  logic [3:0] AWLEN,
    input  logic [3:0] AWID,
    output logic       AWREADY,
    input  logic       WVALID,
    input  logic [7:0] WDATA,
    input  logic       WLAST,
    output logic       WREADY,
    output logic       BVALID,
    input  logic       BREADY,
    output logic [1:0] BRESP,
    output logic [3:0] BID
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [0:0] r_state;
    logic [7:0] r_addr;
    logic [3:0] r_len;
    logic [3:0] r_beat;

    logic [1:0] w_state;
    logic [7:0] w_addr;
    logic [3:0] w_len;
    logic [3:0] w_beat;
    logic [3:0] w_id;
    logic       w_err;

    logic [7:0] rd_addr;
    logic       rd_ok;
    logic [7:0] ram_rdata;
    logic       w_hs;
    logic       w_ok;
    logic       w_last_beat;
    logic       w_err_next;
    logic       ram_we;

    // Read port looks one beat ahead so the next beat is registered on the handshake edge.
    assign rd_addr = (r_state == R_IDLE) ? ARADDR : (r_addr + 8'd1);
    assign rd_ok   = addr_in_range(rd_addr, MEM_DEPTH);

    assign w_hs        = WVALID && WREADY;
    assign w_ok        = addr_in_range(w_addr, MEM_DEPTH);
    assign w_last_beat = (w_beat == w_len);
    assign w_err_next  = w_err || !w_ok || (WLAST != w_last_beat);
    assign ram_we      = (w_state == W_DATA) && w_hs && w_ok;

    axi_burst_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_addr[AW-1:0]),
        .wdata (WDATA),
        .raddr (rd_addr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RID     <= '0;
            RLAST   <= 1'b0;
        end else if (r_state == R_IDLE) begin
            if (ARVALID && ARREADY) begin
                r_state <= R_DATA;
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_beat  <= '0;
                ARREADY <= 1'b0;
                RVALID  <= 1'b1;
                RDATA   <= rd_ok ? ram_rdata : 8'h00;
                RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                RID     <= ARID;
                RLAST   <= (ARLEN == 4'd0);
            end else begin
                ARREADY <= 1'b1;
            end
        end else if (RVALID && RREADY) begin
            if (r_beat == r_len) begin
                r_state <= R_IDLE;
                RVALID  <= 1'b0;
                RLAST   <= 1'b0;
                ARREADY <= 1'b1;
            end else begin
                r_addr <= r_addr + 8'd1;
                r_beat <= r_beat + 4'd1;
                RDATA  <= rd_ok ? ram_rdata : 8'h00;
                RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                RLAST  <= ((r_beat + 4'd1) == r_len);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            BID     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        w_state <= W_DATA;
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_beat  <= '0;
                        w_id    <= AWID;
                        w_err   <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Beat count comes from AWLEN alone; WLAST only feeds the error flag.
                    if (w_hs) begin
                        w_err  <= w_err_next;
                        w_addr <= w_addr + 8'd1;
                        w_beat <= w_beat + 4'd1;
                        if (w_last_beat) begin
                            w_state <= W_RESP;
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                            BID     <= w_id;
                        end
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        w_state <= W_IDLE;
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_responder.sv
// Directed bench for axi_burst_responder: a 256-byte instance and a 128-byte
// instance share the same stimulus so range errors can be seen on the small one.
module tb_axi_burst_responder;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ARVALID = 0, RREADY = 0, AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0;
    logic [7:0] ARADDR = 0, AWADDR = 0, WDATA = 0;
    logic [3:0] ARLEN = 0, ARID = 0, AWLEN = 0, AWID = 0;

    logic       ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID;
    logic [7:0] RDATA;
    logic [1:0] RRESP, BRESP;
    logic [3:0] RID, BID;

    logic       m_ARREADY, m_RVALID, m_RLAST, m_AWREADY, m_WREADY, m_BVALID;
    logic [7:0] m_RDATA;
    logic [1:0] m_RRESP, m_BRESP;
    logic [3:0] m_RID, m_BID;

    axi_burst_responder u_dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
    );

    axi_burst_responder #(.MEM_DEPTH(128)) u_dut128 (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARREADY(m_ARREADY),
        .RVALID(m_RVALID), .RREADY(RREADY), .RDATA(m_RDATA), .RRESP(m_RRESP), .RID(m_RID), .RLAST(m_RLAST),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID), .AWREADY(m_AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(m_WREADY),
        .BVALID(m_BVALID), .BREADY(BREADY), .BRESP(m_BRESP), .BID(m_BID)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wbuf    [16];
    logic [7:0] rd_data [16];
    logic [1:0] rd_resp [16];
    logic       rd_last [16];
    logic [3:0] rd_id   [16];
    logic [7:0] m_data  [16];
    logic [1:0] m_resp  [16];
    int         rd_cycles;
    logic [1:0] b_resp, m_bresp;
    logic [3:0] b_id;

    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input logic [3:0] id,
                            input int last_beat);
        int n;
        int ln;
        ln = int'(len);
        n = 0;
        while (!AWREADY && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (!AWREADY) begin n_fail++; $display("FAIL aw_ready_wait: AWREADY=%b want 1", AWREADY); end
        AWVALID = 1; AWADDR = a; AWLEN = len; AWID = id;
        @(negedge clk);
        AWVALID = 0;
        n_checks++;
        if (WREADY !== 1'b1) begin n_fail++; $display("FAIL wready_after_aw: got %b want 1", WREADY); end
        for (int b = 0; b <= ln; b++) begin
            WVALID = 1; WDATA = wbuf[b]; WLAST = (b == last_beat);
            @(negedge clk);
        end
        WVALID = 0; WLAST = 0;
        n_checks++;
        if (BVALID !== 1'b1 || WREADY !== 1'b0) begin
            n_fail++; $display("FAIL bvalid_after_last: BVALID=%b WREADY=%b want 1 0", BVALID, WREADY);
        end
        b_resp = BRESP; b_id = BID; m_bresp = m_BRESP;
        BREADY = 1;
        @(negedge clk);
        BREADY = 0;
        n_checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_fail++; $display("FAIL b_handshake: BVALID=%b AWREADY=%b want 0 1", BVALID, AWREADY);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input logic [3:0] id,
                           input logic [31:0] rpat);
        int n, nb, k, ln;
        logic have_hold;
        logic [14:0] hold;
        ln = int'(len);
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (!ARREADY) begin n_fail++; $display("FAIL ar_ready_wait: ARREADY=%b want 1", ARREADY); end
        ARVALID = 1; ARADDR = a; ARLEN = len; ARID = id;
        @(negedge clk);
        ARVALID = 0;
        nb = 0; k = 0; have_hold = 0; hold = '0;
        while (nb <= ln && k < 64) begin
            RREADY = (k < 32) ? rpat[k] : 1'b1;
            if (have_hold && RVALID) begin
                n_checks++;
                if ({RDATA, RRESP, RLAST, RID} !== hold) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h want %h", {RDATA, RRESP, RLAST, RID}, hold);
                end
            end
            have_hold = RVALID && !RREADY;
            hold = {RDATA, RRESP, RLAST, RID};
            if (RVALID && RREADY) begin
                rd_data[nb] = RDATA; rd_resp[nb] = RRESP; rd_last[nb] = RLAST; rd_id[nb] = RID;
                m_data[nb] = m_RDATA; m_resp[nb] = m_RRESP;
                nb++;
            end
            @(negedge clk);
            k++;
        end
        RREADY = 0;
        rd_cycles = k;
        n_checks++;
        if (nb != ln + 1) begin n_fail++; $display("FAIL read_beats: got %0d want %0d", nb, ln + 1); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ARREADY, AWREADY, RVALID, RDATA, RRESP, RID, RLAST, WREADY, BVALID, BRESP, BID} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero in reset");
        end
        n_checks++;
        if ({m_ARREADY, m_AWREADY, m_RVALID, m_RDATA, m_RRESP, m_RID, m_RLAST, m_WREADY,
             m_BVALID, m_BRESP, m_BID} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_128: some output nonzero in reset");
        end
        rst = 0;
        #1;
        n_checks++;
        if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL arready_before_edge: got %b want 0", ARREADY); end
        @(negedge clk);
        n_checks++;
        if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_release: AR=%b AW=%b want 1 1", ARREADY, AWREADY);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hA4;
        for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
        do_write(8'h10, 4'd3, 4'd5, 3);
        n_checks++;
        if (b_resp !== OKAY || b_id !== 4'd5) begin
            n_fail++; $display("FAIL basic_bresp: got resp=%b id=%0d want 00 5", b_resp, b_id);
        end
        do_read(8'h10, 4'd3, 4'd9, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !== {exp_d[i], OKAY, (i == 3), 4'd9}) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got d=%h r=%b l=%b id=%0d want d=%h r=00 l=%b id=9",
                         i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp_d[i], (i == 3));
            end
        end
        n_checks++;
        if (rd_cycles != 4) begin n_fail++; $display("FAIL read_throughput: got %0d cycles want 4", rd_cycles); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hA4;
        do_read(8'h10, 4'd3, 4'd3, 32'h0000_0039);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got d=%h l=%b want d=%h l=%b", i, rd_data[i], rd_last[i], exp_d[i], (i == 3));
            end
        end
        n_checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0 || RLAST !== 1'b0) begin
            n_fail++; $display("FAIL stall_end: AR=%b RV=%b RL=%b want 1 0 0", ARREADY, RVALID, RLAST);
        end
    endtask

    task automatic test_wrap();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 4'd2, 4'd1, 2);
        n_checks++;
        if (b_resp !== OKAY) begin n_fail++; $display("FAIL wrap_bresp: got %b want 00", b_resp); end
        do_read(8'hFE, 4'd2, 4'd2, 32'hFFFF_FFFF);
        n_checks++;
        if ({rd_data[0], rd_data[1], rd_data[2]} !== 24'h112233) begin
            n_fail++; $display("FAIL wrap_data: got %h%h%h want 112233", rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_range();
        wbuf[0] = 8'h5C;
        do_write(8'h7F, 4'd0, 4'd1, 0);
        n_checks++;
        if (b_resp !== OKAY || m_bresp !== OKAY) begin
            n_fail++; $display("FAIL range_write_7f: got %b/%b want 00/00", b_resp, m_bresp);
        end
        do_read(8'h7F, 4'd1, 4'd2, 32'hFFFF_FFFF);
        n_checks++;
        if (m_data[0] !== 8'h5C || m_resp[0] !== OKAY) begin
            n_fail++; $display("FAIL range_beat0: got d=%h r=%b want d=5c r=00", m_data[0], m_resp[0]);
        end
        n_checks++;
        if (m_data[1] !== 8'h00 || m_resp[1] !== SLV) begin
            n_fail++; $display("FAIL range_beat1: got d=%h r=%b want d=00 r=10", m_data[1], m_resp[1]);
        end
        n_checks++;
        if (rd_resp[1] !== OKAY) begin n_fail++; $display("FAIL range_beat1_256: got %b want 00", rd_resp[1]); end
        wbuf[0] = 8'h77;
        do_write(8'h80, 4'd0, 4'd3, 0);
        n_checks++;
        if (m_bresp !== SLV || b_resp !== OKAY) begin
            n_fail++; $display("FAIL range_write_80: got %b/%b want 10/00", m_bresp, b_resp);
        end
    endtask

    task automatic test_wlast();
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        do_write(8'h20, 4'd3, 4'd6, 1);
        n_checks++;
        if (b_resp !== SLV || b_id !== 4'd6) begin
            n_fail++; $display("FAIL wlast_bresp: got resp=%b id=%0d want 10 6", b_resp, b_id);
        end
        do_read(8'h20, 4'd3, 4'd0, 32'hFFFF_FFFF);
        n_checks++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== 32'h01020304) begin
            n_fail++; $display("FAIL wlast_data: got %h%h%h%h want 01020304",
                               rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
    endtask

    task automatic test_reset_mid_burst();
        n_checks++;
        if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin
            n_fail++; $display("FAIL mid_start_ready: AR=%b AW=%b want 1 1", ARREADY, AWREADY);
        end
        ARVALID = 1; ARADDR = 8'h10; ARLEN = 4'd4; ARID = 4'd7;
        AWVALID = 1; AWADDR = 8'h40; AWLEN = 4'd4; AWID = 4'd2;
        @(negedge clk);
        ARVALID = 0; AWVALID = 0; RREADY = 1;
        WVALID = 1; WDATA = 8'hC0; WLAST = 0;
        @(negedge clk);
        WDATA = 8'hC1;
        @(negedge clk);
        n_checks++;
        if (RVALID !== 1'b1 || RDATA !== 8'hA3 || RID !== 4'd7) begin
            n_fail++; $display("FAIL mid_beat2: RV=%b d=%h id=%0d want 1 a3 7", RVALID, RDATA, RID);
        end
        rst = 1; RREADY = 0; WVALID = 0;
        #1;
        n_checks++;
        if ({ARREADY, AWREADY, RVALID, RDATA, RRESP, RID, RLAST, WREADY, BVALID, BRESP, BID} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: some output nonzero after async reset");
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (ARREADY !== 1'b1 || AWREADY !== 1'b1 || RVALID !== 1'b0 || WREADY !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: AR=%b AW=%b RV=%b WR=%b want 1 1 0 0",
                               ARREADY, AWREADY, RVALID, WREADY);
        end
        do_read(8'h40, 4'd1, 4'd4, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== 8'hC0 || rd_data[1] !== 8'hC1) begin
            n_fail++; $display("FAIL mid_preserved: got %h %h want c0 c1", rd_data[0], rd_data[1]);
        end
        do_read(8'h10, 4'd0, 4'd4, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data[0] !== 8'hA1) begin n_fail++; $display("FAIL mid_old_data: got %h want a1", rd_data[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_range();
        test_wlast();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_burst_responder.md
# axi_burst_responder

Memory-backed responder for the team's simplified AXI-style burst interface; it is the far end of the bus master, answering its read and write bursts. It accepts read address (AR) and write address (AW) requests, streams read beats on R, absorbs write beats on W, and returns a write response on B, all with valid/ready handshakes. Read and write paths run concurrently and share one byte-addressed storage array.

## Interface
- MEM_DEPTH, 256: number of bytes of storage; valid byte addresses are 0..MEM_DEPTH-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ARVALID  in  1  read address valid.
- ARADDR  in  8  read start byte address.
- ARLEN  in  4  read beats minus one (1..16 beats).
- ARID  in  4  read transaction ID.
- ARREADY  out  1  read address accepted.
- RVALID  out  1  read beat valid.
- RREADY  in  1  master accepts read beat.
- RDATA  out  8  read byte.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RID  out  4  echoes ARID.
- RLAST  out  1  final read beat.
- AWVALID  in  1  write address valid.
- AWADDR  in  8  write start byte address.
- AWLEN  in  4  write beats minus one.
- AWID  in  4  write transaction ID.
- AWREADY  out  1  write address accepted.
- WVALID  in  1  write beat valid.
- WDATA  in  8  write byte.
- WLAST  in  1  master marks final write beat.
- WREADY  out  1  write beat accepted.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts response.
- BRESP  out  2  write response: OKAY or SLVERR.
- BID  out  4  echoes AWID.

## Operation
- A handshake occurs on a rising edge where VALID and READY are both 1. All outputs are registered.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, ARREADY=1. On AR handshake, latch ARADDR, ARLEN, ARID; go to R_DATA; set ARREADY=0 and RVALID=1; present beat 0.
  - In R_DATA, RDATA, RRESP, RLAST and RID are held stable while RVALID=1 and RREADY=0.
  - On an R handshake that is not the last beat, increment the address and present the next beat.
  - On the last-beat handshake (beat index == ARLEN), set RVALID=0 and RLAST=0, set ARREADY=1, return to R_IDLE.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - In W_IDLE, AWREADY=1. On AW handshake, latch AWADDR, AWLEN, AWID; set AWREADY=0 and WREADY=1; go to W_DATA.
  - Each W handshake writes WDATA to the current address and increments the address.
  - Exactly AWLEN+1 beats are accepted regardless of WLAST.
  - A WLAST mismatch on any beat (WLAST != (beat==AWLEN)) sets a sticky error flag.
  - After the final beat, set WREADY=0 and BVALID=1; BID = latched AWID; BRESP = SLVERR if the error flag is set, else OKAY; go to W_RESP.
  - On B handshake, set BVALID=0 and AWREADY=1; return to W_IDLE.
- Address arithmetic is 8-bit. Incrementing from 255 wraps to 0.
- A beat whose address is >= MEM_DEPTH is out of range:
  - Read: RDATA=0 and RRESP=SLVERR for that beat only.
  - Write: the byte is dropped and the error flag is set.
- Simultaneous read and write of the same byte on one edge: the read beat loaded on that edge returns the old value (read-before-write).
- Read and write FSMs are fully independent; no arbitration is needed.

## Timing
- Reset values: ARREADY=0, AWREADY=0, RVALID=0, RDATA=0, RRESP=0, RID=0, RLAST=0, WREADY=0, BVALID=0, BRESP=0, BID=0. Both FSMs go to IDLE.
- ARREADY and AWREADY rise on the first clk edge after rst deasserts.
- AR handshake at edge N: beat 0 is valid after edge N.
- Throughput is one beat per cycle while RREADY stays high.
- Minimum spacing between AR handshakes is ARLEN+2 cycles.
- AW handshake at edge N: WREADY=1 after edge N. Last W beat at edge M: BVALID=1 after edge M.
- Reset mid-burst aborts both bursts and drives outputs to their reset values. Storage contents are preserved and are never initialised by rst.

## Structure
- Package axi_burst_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Read state encodings R_IDLE, R_DATA; write state encodings W_IDLE, W_DATA, W_RESP.
- Sub-module axi_burst_ram: MEM_DEPTH x 8 storage with one synchronous write port and one asynchronous read port. The responder registers the read-port output into RDATA.

## Test plan
- Write AWADDR=0x10, AWLEN=3, AWID=5, WDATA=A1,A2,A3,A4 with WLAST on beat 3 -> BVALID with BID=5, BRESP=OKAY. Then read ARADDR=0x10, ARLEN=3, ARID=9 -> RDATA A1..A4, RID=9, RLAST only on beat 3, RRESP=OKAY.
- Read 4 beats with RREADY toggled 1,0,0,1,1,1 -> beats held stable during stalls, no beat lost or repeated, ARREADY returns the cycle after the last handshake.
- Write AWADDR=0xFE, AWLEN=2 (bytes 11,22,33), then read the same range -> addresses FE, FF, 00 return 11, 22, 33.
- With MEM_DEPTH=128: read ARADDR=0x7F, ARLEN=1 -> beat 0 OKAY with stored data, beat 1 RDATA=0 and RRESP=SLVERR. Write to 0x80 -> BRESP=SLVERR.
- Write AWLEN=3 with WLAST on beat 1 -> four beats still accepted, BRESP=SLVERR.
- Assert rst during beat 2 of a 5-beat read and a concurrent write -> all outputs at reset values the same cycle; after release, reading bytes already written returns the written values.
